mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter ADDR_W, 16, address width.
REQ-002 Parameter DATA_W, 32, data width.
REQ-003 Parameter TMO_CYC, 15, cycles waited for MEM_ACK before abort (timeout build only).
REQ-004 One clock; reset is asynchronous and active-low. Ports are listed next.
REQ-005 CLK  in  1  clock, all state updates on rising edge.
REQ-006 RST_F  in  1  asynchronous active-low reset.
REQ-007 IF_REQ  in  1  fetch request, held until IF_DONE.
REQ-008 IF_ADDR  in  ADDR_W  fetch address.
REQ-009 DM_REQ  in  1  data request, held until DM_DONE.
REQ-010 DM_WE  in  1  data write enable (1 = store, 0 = load).
REQ-011 DM_ADDR  in  ADDR_W  data address.
REQ-012 DM_WDATA  in  DATA_W  store data.
REQ-013 MEM_REQ  out  1  memory request, registered.
REQ-014 MEM_WE  out  1  memory write enable, registered.
REQ-015 MEM_ADDR  out  ADDR_W  memory address, registered.
REQ-016 MEM_WDATA  out  DATA_W  memory write data, registered.
REQ-017 MEM_RDATA  in  DATA_W  memory read data, valid with MEM_ACK.
REQ-018 MEM_ACK  in  1  memory completion, single-cycle pulse.
REQ-019 IF_DONE  out  1  one-cycle fetch completion pulse.
REQ-020 DM_DONE  out  1  one-cycle data completion pulse.
REQ-021 RDATA  out  DATA_W  captured read data, valid while IF_DONE or DM_DONE is high.
REQ-022 ERR  out  1  abort flag, high with DONE when the transaction timed out.
REQ-023 BUSY  out  1  high in every state other than IDLE.

Function
REQ-024 The FSM has states IDLE, BUSY and RESP, with transitions IDLE->BUSY->RESP->IDLE.
REQ-025 IDLE: if any REQ is high at the edge, latch the owner, address, WE and WDATA, set MEM_REQ, and go to BUSY.
REQ-026 Arbitration when only one requester is active: that requester wins.
REQ-027 Arbitration when both are active: DM wins unless the last grant was DM, in which case IF wins.
REQ-028 BUSY: hold MEM_REQ and the latched MEM_* values stable until MEM_ACK.
REQ-029 BUSY, on the MEM_ACK cycle: clear MEM_REQ and MEM_WE, capture MEM_RDATA into RDATA (captured for stores too), and go to RESP.
REQ-030 RESP: pulse the owner's DONE for exactly one cycle, then go to IDLE.
REQ-031 Minimum cycle count from REQ sample to DONE is 2 plus the memory wait: MEM_REQ is high for 1 cycle when the ACK arrives on the first BUSY cycle.
REQ-032 REQ is not sampled in RESP; back-to-back requests incur one IDLE cycle.
REQ-033 A requester dropping REQ during BUSY does not cancel the transaction; its DONE still pulses.
REQ-034 MEM_ACK received in IDLE or RESP is ignored.
REQ-035 IF transactions always drive MEM_WE = 0.

Reset
REQ-036 While RST_F is low, the state is IDLE immediately, independent of CLK.
REQ-037 While RST_F is low, all outputs are 0.
REQ-038 While RST_F is low, the last-grant register is set to IF, so DM wins the first contention.
REQ-039 A reset during BUSY abandons the transaction and produces no DONE pulse.

Configuration
REQ-040 With MEM_ARB_TIMEOUT_EN defined, a cycle counter runs in BUSY.
REQ-041 In the timeout build, when the counter reaches TMO_CYC without MEM_ACK, clear MEM_REQ, set RDATA to 0, and go to RESP with ERR high alongside DONE.
REQ-042 In the timeout build, the counter clears on entry to BUSY.
REQ-043 Without MEM_ARB_TIMEOUT_EN, BUSY waits indefinitely, ERR is constant 0, and no counter logic exists.

Structure
REQ-044 Shared package mem_arb_pkg holds the state encodings (IDLE, BUSY, RESP), the owner encoding (OWN_IF, OWN_DM) and the TMO_CYC default.
REQ-045 One sub-module, mem_arb_tmo, provides the timeout counter and is instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-046 IF_REQ, IF_ADDR=0x0010; MEM_ACK on the 1st BUSY cycle with MEM_RDATA=0x8100_0005 -> MEM_ADDR=0x0010, MEM_WE=0, IF_DONE one cycle, RDATA=0x8100_0005.
REQ-047 DM_REQ with DM_WE=1, DM_ADDR=0x0200, DM_WDATA=0xDEAD_BEEF; ACK after 3 cycles -> MEM_WE=1 and MEM_WDATA stable 3 cycles, then a DM_DONE pulse.
REQ-048 IF_REQ and DM_REQ held together for 4 transactions -> grant order DM, IF, DM, IF.
REQ-049 RST_F low mid-BUSY -> MEM_REQ=0 and BUSY=0 immediately, no DONE; after release, DM wins the next contention.
REQ-050 Timeout build, TMO_CYC=15, no ACK -> MEM_REQ drops after 15 BUSY cycles, then DONE=1, ERR=1, RDATA=0.
REQ-051 Non-timeout build, no ACK for 100 cycles -> MEM_REQ stays high and ERR stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the fetch/data memory
//               arbiter. Holds the FSM state encoding, the owner encoding,
//               the timeout default and the grant-selection helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    localparam int unsigned TMO_CYC_DEF = 15;

    // Grant selection. A lone requester always wins. Under contention the
    // data port wins unless it also took the previous grant, which gives
    // strict alternation while both ports keep requesting.
    function automatic owner_e arb_pick(input logic   if_req,
                                        input logic   dm_req,
                                        input owner_e last);
        owner_e pick;
        pick = OWN_IF;
        if (dm_req && (!if_req || (last != OWN_DM))) begin
            pick = OWN_DM;
        end
        return pick;
    endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_tmo.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_tmo
// Description : BUSY-state cycle counter for the memory arbiter. It is built
//               only when MEM_ARB_TIMEOUT_EN is defined.
//               expired_o is high during the TMO_CYC-th consecutive BUSY cycle.
// Ports       : clk_i     - clock
//               rst_ni    - asynchronous active-low reset
//               start_i   - transaction accepted this cycle (clears count)
//               run_i     - arbiter is in BUSY
//               expired_o - wait budget exhausted in this BUSY cycle
// Revision    : 1.0 - initial release
// ============================================================================
import mem_arb_pkg::*;

module mem_arb_tmo #(
    parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TMO_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // cnt_q holds the index (0-based) of the current BUSY cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (start_i) begin
            cnt_q <= '0;
        end else if (run_i && (cnt_q != C_LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = run_i && (cnt_q == C_LAST);

endmodule : mem_arb_tmo
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb
// Description : Two-port (instruction fetch / data) arbiter in front of a
//               single request/acknowledge memory port. IDLE -> BUSY -> RESP
//               -> IDLE, one transaction at a time, all outputs registered.
//               Optional build macro MEM_ARB_TIMEOUT_EN adds a BUSY timeout
//               (mem_arb_tmo) that aborts with ERR after TMO_CYC cycles.
// Ports       : CLK, RST_F          - clock, async active-low reset
//               IF_REQ/IF_ADDR     - fetch request (read only)
//               DM_REQ/DM_WE/DM_ADDR/DM_WDATA - data request
//               MEM_REQ/MEM_WE/MEM_ADDR/MEM_WDATA - memory request side
//               MEM_RDATA/MEM_ACK  - memory response side
//               IF_DONE/DM_DONE    - one-cycle completion pulses
//               RDATA/ERR/BUSY     - response data, abort flag, busy flag
// Revision    : 1.0 - initial release
// ============================================================================
import mem_arb_pkg::*;

module mem_arb #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
    input  logic              CLK,
    input  logic              RST_F,
    input  logic              IF_REQ,
    input  logic [ADDR_W-1:0] IF_ADDR,
    input  logic              DM_REQ,
    input  logic              DM_WE,
    input  logic [ADDR_W-1:0] DM_ADDR,
    input  logic [DATA_W-1:0] DM_WDATA,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_ACK,
    output logic              IF_DONE,
    output logic              DM_DONE,
    output logic [DATA_W-1:0] RDATA,
    output logic              ERR,
    output logic              BUSY
);

    state_e            state_q;
    owner_e            owner_q;
    owner_e            last_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              if_done_q;
    logic              dm_done_q;
    logic              err_q;

    owner_e            grant_d;
    logic              w_any_req;
    logic              w_tmo;

    assign w_any_req = IF_REQ || DM_REQ;
    assign grant_d   = arb_pick(IF_REQ, DM_REQ, last_q);

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_tmo #(
        .TMO_CYC   (TMO_CYC)
    ) u_tmo (
        .clk_i     (CLK),
        .rst_ni    (RST_F),
        .start_i   ((state_q == ST_IDLE) && w_any_req),
        .run_i     (state_q == ST_BUSY),
        .expired_o (w_tmo)
    );
`else
    // No timeout: BUSY waits for MEM_ACK forever and ERR can never rise.
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            // Last grant reads as IF so the data port wins first contention.
            last_q      <= OWN_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // MEM_ACK is deliberately not looked at here.
                    if (w_any_req) begin
                        owner_q   <= grant_d;
                        last_q    <= grant_d;
                        mem_req_q <= 1'b1;
                        if (grant_d == OWN_DM) begin
                            mem_we_q    <= DM_WE;
                            mem_addr_q  <= DM_ADDR;
                            mem_wdata_q <= DM_WDATA;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= IF_ADDR;
                            mem_wdata_q <= '0;
                        end
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Requests are not re-examined: a dropped REQ still
                    // completes. ACK takes precedence over a same-cycle timeout.
                    if (MEM_ACK) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        rdata_q   <= MEM_RDATA;
                        if_done_q <= (owner_q == OWN_IF);
                        dm_done_q <= (owner_q == OWN_DM);
                        state_q   <= ST_RESP;
                    end else if (w_tmo) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        if_done_q <= (owner_q == OWN_IF);
                        dm_done_q <= (owner_q == OWN_DM);
                        state_q   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if_done_q <= 1'b0;
                    dm_done_q <= 1'b0;
                    err_q     <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign MEM_REQ   = mem_req_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign IF_DONE   = if_done_q;
    assign DM_DONE   = dm_done_q;
    assign RDATA     = rdata_q;
    assign ERR       = err_q;
    assign BUSY      = (state_q != ST_IDLE);

endmodule : mem_arb
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arb
// Description : Directed self-checking bench for mem_arb. Expected values
//               are hand-computed constants. The timeout scenario is chosen
//               by MEM_ARB_TIMEOUT_EN, matching the DUT build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arb;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TMO_CYC = 15;

    logic              CLK = 1'b0;
    logic              RST_F;
    logic              IF_REQ;
    logic [ADDR_W-1:0] IF_ADDR;
    logic              DM_REQ;
    logic              DM_WE;
    logic [ADDR_W-1:0] DM_ADDR;
    logic [DATA_W-1:0] DM_WDATA;
    logic              MEM_REQ;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [DATA_W-1:0] MEM_RDATA;
    logic              MEM_ACK;
    logic              IF_DONE;
    logic              DM_DONE;
    logic [DATA_W-1:0] RDATA;
    logic              ERR;
    logic              BUSY;

    int total = 0;
    int bad   = 0;

    mem_arb #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .TMO_CYC   (TMO_CYC)
    ) dut (
        .CLK       (CLK),
        .RST_F     (RST_F),
        .IF_REQ    (IF_REQ),
        .IF_ADDR   (IF_ADDR),
        .DM_REQ    (DM_REQ),
        .DM_WE     (DM_WE),
        .DM_ADDR   (DM_ADDR),
        .DM_WDATA  (DM_WDATA),
        .MEM_REQ   (MEM_REQ),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_RDATA (MEM_RDATA),
        .MEM_ACK   (MEM_ACK),
        .IF_DONE   (IF_DONE),
        .DM_DONE   (DM_DONE),
        .RDATA     (RDATA),
        .ERR       (ERR),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle; inputs are driven and outputs
    // sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_F = 1'b0; IF_REQ = 1'b0; IF_ADDR = '0; DM_REQ = 1'b0; DM_WE = 1'b0;
        DM_ADDR = '0; DM_WDATA = '0; MEM_RDATA = '0; MEM_ACK = 1'b0;

        // ---------------- reset state ----------------
        #2;
        check("rst_mem_req", MEM_REQ, 1'b0);
        check("rst_busy",    BUSY,    1'b0);
        check("rst_done",    {IF_DONE, DM_DONE, ERR, MEM_WE}, 4'b0000);
        check("rst_addr",    MEM_ADDR, 16'h0000);
        check("rst_rdata",   RDATA,    32'h0);
        tick(); tick();
        RST_F = 1'b1;
        tick();

        // ---------------- DM store, ACK on 3rd BUSY cycle ----------------
        DM_REQ = 1'b1; DM_WE = 1'b1; DM_ADDR = 16'h0200; DM_WDATA = 32'hDEAD_BEEF;
        tick();
        check("st_c1_req",   MEM_REQ,   1'b1);
        check("st_c1_we",    MEM_WE,    1'b1);
        check("st_c1_addr",  MEM_ADDR,  16'h0200);
        check("st_c1_wdata", MEM_WDATA, 32'hDEAD_BEEF);
        check("st_c1_busy",  BUSY,      1'b1);
        tick();
        check("st_c2_we",    MEM_WE,    1'b1);
        check("st_c2_wdata", MEM_WDATA, 32'hDEAD_BEEF);
        check("st_c2_done",  DM_DONE,   1'b0);
        tick();
        check("st_c3_we",    MEM_WE,    1'b1);
        check("st_c3_wdata", MEM_WDATA, 32'hDEAD_BEEF);
        MEM_ACK = 1'b1; MEM_RDATA = 32'h0000_1234;
        tick();
        MEM_ACK = 1'b0;
        check("st_resp_dm_done", DM_DONE, 1'b1);
        check("st_resp_if_done", IF_DONE, 1'b0);
        check("st_resp_req",     MEM_REQ, 1'b0);
        check("st_resp_we",      MEM_WE,  1'b0);
        check("st_resp_rdata",   RDATA,   32'h0000_1234);
        check("st_resp_busy",    BUSY,    1'b1);
        DM_REQ = 1'b0; DM_WE = 1'b0;
        tick();
        check("st_idle_done", DM_DONE, 1'b0);
        check("st_idle_busy", BUSY,    1'b0);

        // ---------------- IF fetch, ACK on 1st BUSY cycle ----------------
        IF_REQ = 1'b1; IF_ADDR = 16'h0010;
        tick();
        check("if_addr", MEM_ADDR, 16'h0010);
        check("if_we",   MEM_WE,   1'b0);
        check("if_req",  MEM_REQ,  1'b1);
        MEM_ACK = 1'b1; MEM_RDATA = 32'h8100_0005;
        tick();
        MEM_ACK = 1'b0;
        check("if_done",    IF_DONE, 1'b1);
        check("if_dm_done", DM_DONE, 1'b0);
        check("if_rdata",   RDATA,   32'h8100_0005);
        check("if_req_clr", MEM_REQ, 1'b0);
        IF_REQ = 1'b0;
        tick();
        check("if_done_one_cycle", IF_DONE, 1'b0);

        // ---------------- stray ACK in IDLE is ignored ----------------
        MEM_ACK = 1'b1; MEM_RDATA = 32'h5555_AAAA;
        tick();
        MEM_ACK = 1'b0;
        check("idle_ack_busy",  BUSY,  1'b0);
        check("idle_ack_done",  {IF_DONE, DM_DONE}, 2'b00);
        check("idle_ack_rdata", RDATA, 32'h8100_0005);

        // ---------------- contention: DM, IF, DM, IF ----------------
        IF_REQ = 1'b1; IF_ADDR = 16'h0040;
        DM_REQ = 1'b1; DM_ADDR = 16'h0080; DM_WE = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("arb_addr", MEM_ADDR, (k % 2 == 0) ? 16'h0080 : 16'h0040);
            MEM_ACK = 1'b1; MEM_RDATA = 32'h1000_0000 + k;
            tick();
            MEM_ACK = 1'b0;
            check("arb_if_done", IF_DONE, (k % 2 == 1));
            check("arb_dm_done", DM_DONE, (k % 2 == 0));
            check("arb_rdata",   RDATA,   32'h1000_0000 + k);
            tick();
        end
        IF_REQ = 1'b0; DM_REQ = 1'b0;
        tick();

        // ---------------- reset mid-BUSY ----------------
        DM_REQ = 1'b1; DM_WE = 1'b1; DM_ADDR = 16'h0300; DM_WDATA = 32'h0BAD_F00D;
        tick();
        check("rb_req_before", MEM_REQ, 1'b1);
        #2;
        RST_F = 1'b0;
        #1;
        check("rb_req_async",  MEM_REQ, 1'b0);
        check("rb_busy_async", BUSY,    1'b0);
        check("rb_outs_async", {MEM_WE, IF_DONE, DM_DONE, ERR}, 4'b0000);
        check("rb_addr_async", MEM_ADDR, 16'h0000);
        tick();
        check("rb_no_done_in_rst", {IF_DONE, DM_DONE}, 2'b00);
        DM_REQ = 1'b0; DM_WE = 1'b0;
        RST_F = 1'b1;
        tick();
        check("rb_no_done_after", {IF_DONE, DM_DONE}, 2'b00);
        check("rb_idle_after",    BUSY, 1'b0);
        IF_REQ = 1'b1; IF_ADDR = 16'h0040;
        DM_REQ = 1'b1; DM_ADDR = 16'h0080;
        tick();
        check("rb_dm_wins", MEM_ADDR, 16'h0080);
        MEM_ACK = 1'b1; MEM_RDATA = 32'hCAFE_0001;
        tick();
        MEM_ACK = 1'b0;
        check("rb_dm_done", {IF_DONE, DM_DONE}, 2'b01);
        IF_REQ = 1'b0; DM_REQ = 1'b0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // ---------------- timeout abort after TMO_CYC BUSY cycles ----------------
        IF_REQ = 1'b1; IF_ADDR = 16'h0555; MEM_RDATA = 32'h7777_7777;
        tick();
        check("tmo_c1_req", MEM_REQ, 1'b1);
        for (int i = 2; i <= TMO_CYC; i++) begin
            tick();
            check("tmo_req_held", MEM_REQ, 1'b1);
            check("tmo_err_low",  ERR,     1'b0);
        end
        tick();
        check("tmo_req_drop", MEM_REQ, 1'b0);
        check("tmo_if_done",  IF_DONE, 1'b1);
        check("tmo_err",      ERR,     1'b1);
        check("tmo_rdata",    RDATA,   32'h0);
        IF_REQ = 1'b0;
        tick();
        check("tmo_err_clear", ERR,     1'b0);
        check("tmo_done_clr",  IF_DONE, 1'b0);
`else
        // ---------------- no timeout: 100 cycles without ACK ----------------
        IF_REQ = 1'b1; IF_ADDR = 16'h0555;
        tick();
        for (int i = 0; i < 100; i++) begin
            tick();
            check("nt_req_held", MEM_REQ, 1'b1);
            check("nt_err_low",  ERR,     1'b0);
        end
        MEM_ACK = 1'b1; MEM_RDATA = 32'h0000_0555;
        tick();
        MEM_ACK = 1'b0;
        check("nt_if_done", IF_DONE, 1'b1);
        check("nt_err",     ERR,     1'b0);
        check("nt_rdata",   RDATA,   32'h0000_0555);
        IF_REQ = 1'b0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_arb
`default_nettype wire
